uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the processor's `RX` pin: 8N1 UART, LSB first, fixed baud set by a clock-divider parameter. It synchronises the asynchronous line, samples each bit at mid-period and assembles bytes. Completed bytes are presented to the core side through a one-entry valid/ready holding register. It is the receive-side counterpart of the UART transmitter driving `TX` in `top`, and sits inside `top` between the `RX` pin and the core's I/O bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: CLK cycles per bit period (12 MHz / 115200). Must be ≥ 4. Half-period is `CLKS_PER_BIT/2`, integer division.

Ports:
- `CLK`  in  1  system clock
- `RST`  in  1  reset; asynchronous, active-high
- `RX`  in  1  serial line, idle high, asynchronous to CLK
- `DATA`  out  8  received byte; stable while `VALID`=1
- `VALID`  out  1  holding register full
- `READY`  in  1  consumer accepts `DATA` when `VALID`&`READY`
- `FRAME_ERR`  out  1  one-cycle pulse: stop bit sampled low
- `OVERRUN`  out  1  sticky: a byte was dropped because the holding register was full
- `CLR_ERR`  in  1  clears `OVERRUN` on the next edge

## Operation
- Input path: `RX` passes through a 2-FF synchroniser. Both flops reset to 1. `rx_s` is the synchronised line; `rx_q` is its previous value.
- State machine, 2-bit state:
  - IDLE: on `rx_q`=1 and `rx_s`=0 (falling edge), clear the bit counter and go to START.
  - START: at count `CLKS_PER_BIT/2-1`, sample `rx_s`. If 1 (glitch), go to IDLE. If 0, reset the counter and go to DATA with bit index 0.
  - DATA: each time the counter reaches `CLKS_PER_BIT-1`, shift `rx_s` into the MSB of the shift register (LSB-first assembly) and increment the index. After index 7 is sampled, go to STOP.
  - STOP: at count `CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse `FRAME_ERR`, discard the byte and go to IDLE. IDLE needs a new 1→0 edge, so a held-low line (break) produces no further frames.
- Delivery on the stop-bit sample cycle:
  - Holding register empty: load `DATA`, set `VALID`.
  - Full and `READY`=1 on the same cycle: the old byte is consumed, the new byte is loaded, and `VALID` stays 1.
  - Full and `READY`=0: drop the new byte, keep the old `DATA`, set `OVERRUN`.
- `VALID` clears on `VALID`&`READY` when no new byte loads that cycle. `READY` while `VALID`=0 has no effect.
- `OVERRUN` set takes priority over `CLR_ERR` in the same cycle.
- Counter width: `$clog2(CLKS_PER_BIT)` bits. It wraps to 0 on every sample event and never free-runs outside START, DATA and STOP.

## Timing
- Reset values: `DATA`=0x00, `VALID`=0, `FRAME_ERR`=0, `OVERRUN`=0, state IDLE, synchroniser flops = 1, counter/index/shift register = 0.
- `RST` asserted mid-frame aborts immediately. The partial byte is lost and the block resumes at IDLE after release.
- Sample points, relative to the cycle the falling edge is seen at `rx_s`:
  - start bit: `CLKS_PER_BIT/2`
  - data bit k: `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT`
  - stop bit: `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`
- `VALID` / `FRAME_ERR` are registered and assert on the edge after the stop sample.
- Pin-to-`rx_s` latency: 2 cycles.
- Back-to-back frames (next start bit immediately after the stop bit) must be received without loss. IDLE is re-entered about half a bit period before the next falling edge.
- All outputs are registered. No combinational path from `READY` to `VALID`/`DATA`.

## Structure
- Shared header `uart_defs.v`, included by both `uart_rx` and the transmitter, holds:
  - the state encodings: `UART_IDLE`=0, `UART_START`=1, `UART_DATA`=2, `UART_STOP`=3
  - the default `CLKS_PER_BIT` value
  - the data-bit count (8)
- One sub-module: `bit_sync`, a 2-FF synchroniser with a reset-value parameter. It is reused later for `BTN_N`.
- The FSM, counter, shift register and holding register live in `uart_rx`. Target size is about 150 lines.

## Test plan
Sim uses `CLKS_PER_BIT`=4 and `READY`=1 unless stated.
- Frame 0x55 (line: start 0, bits 1,0,1,0,1,0,1,0, stop 1) → one-cycle `VALID` with `DATA`=0x55 on the edge after the stop sample; `FRAME_ERR`=0.
- Back-to-back frames 0xA3 then 0x0F, no idle gap → two `VALID` pulses, `DATA`=0xA3 then 0x0F, no `OVERRUN`.
- `RX` low for 1 cycle, then high → no `VALID`, no `FRAME_ERR`, state back in IDLE by cycle 2 after the glitch reaches `rx_s`.
- Frame 0x0F with stop bit 0 → `FRAME_ERR` pulses for 1 cycle; `VALID`=0, `DATA` unchanged. A following good frame 0x81 is received.
- `READY`=0, frames 0x11 then 0x22 → `DATA`=0x11 held, `VALID`=1, `OVERRUN`=1. Then `READY`=1 for one cycle → `VALID`=0. Then `CLR_ERR` → `OVERRUN`=0.
- `RST` pulsed after data bit 3 of a frame → all outputs 0 immediately. The next full frame 0xC6 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: definitions shared by the UART receive path and its
// transmit-side counterpart.
//   uart_state_e          - 2-bit frame-tracking state encoding
//   UART_CLKS_PER_BIT_DEF - default baud divider (12 MHz / 115200)
//   UART_DATA_BITS        - data bits per frame
//   UART_IDX_W            - width of a bit index inside the data field
package uart_rx_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT_DEF = 104;
  localparam int UART_DATA_BITS        = 8;
  localparam int UART_IDX_W            = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_rx_bit_sync.sv
// bit_sync: two-flop synchroniser for a single asynchronous input.
// Both flops reset to RST_VAL so that the synchronised line shows the
// input's idle level while reset is held.
//   clk_i - destination clock
//   rst_i - asynchronous, active-high reset
//   d_i   - asynchronous input
//   q_o   - synchronised output, two clk_i cycles behind d_i
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, fixed baud given by CLKS_PER_BIT.
// The line is synchronised, each bit is sampled at mid-period, and finished
// bytes are handed to the core through a one-entry valid/ready register.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a 1->0 edge on the synchronised line
// START | timing half a bit to re-check the start bit (glitch filter)
// DATA  | sampling the 8 data bits, one per bit period
// STOP  | sampling the stop bit, then delivering or flagging the frame
//
//   CLK       - system clock
//   RST       - asynchronous, active-high reset
//   RX        - serial line, idle high, asynchronous to CLK
//   DATA      - received byte, stable while VALID is high
//   VALID     - holding register full
//   READY     - consumer takes DATA when VALID & READY
//   FRAME_ERR - one-cycle pulse when a stop bit is sampled low
//   OVERRUN   - sticky, a byte was dropped because the holding reg was full
//   CLR_ERR   - clears OVERRUN on the next edge
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  input  logic       CLR_ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]         HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]         FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [UART_IDX_W-1:0] LAST_BIT = UART_IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;
  logic rx_q;

  uart_state_e           state_q;
  logic [CW-1:0]         cnt_q;
  logic [UART_IDX_W-1:0] idx_q;
  logic [7:0]            shift_q;
  logic [7:0]            data_q;
  logic                  valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  bit_sync #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (RX),
    .q_o  (rx_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_q        <= 1'b1;
      state_q     <= UART_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_q        <= rx_s;
      frame_err_q <= 1'b0;

      // Consumer handshake and error clear; a delivery below overrides both.
      if (valid_q && READY) valid_q <= 1'b0;
      if (CLR_ERR) overrun_q <= 1'b0;

      case (state_q)
        UART_IDLE: begin
          if (rx_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= UART_START;
          end
        end

        UART_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= UART_IDLE;
            end else begin
              idx_q   <= '0;
              state_q <= UART_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        UART_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            idx_q   <= idx_q + UART_IDX_W'(1);
            if (idx_q == LAST_BIT) state_q <= UART_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        UART_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= UART_IDLE;
            if (rx_s) begin
              // A same-cycle READY frees the slot, so the new byte still lands.
              if (!valid_q || READY) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: state_q <= UART_IDLE;
      endcase
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CLKS_PER_BIT = 4. Each segment builds a
// per-cycle table of RX / READY / CLR_ERR values, decodes the expected
// frames straight from the line waveform using the receiver's sample-point
// rules, and checks every DUT output on every cycle against a
// holding-register model.
module tb_uart_rx;

  localparam int N    = 4;
  localparam int H    = N / 2;
  localparam int MAXL = 4096;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX = 1'b1;
  logic       READY = 1'b1;
  logic       CLR_ERR = 1'b0;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX       (RX),
    .DATA     (DATA),
    .VALID    (VALID),
    .READY    (READY),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN  (OVERRUN),
    .CLR_ERR  (CLR_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus tables, indexed by posedge number after reset release.
  logic line_a [MAXL];
  logic rdy_a  [MAXL];
  logic clr_a  [MAXL];
  int   len;
  logic cur_rdy;
  logic rnd_mode;

  // Decoded events: 0 none, 1 good byte, 2 framing error.
  int         ev_kind [MAXL];
  logic [7:0] ev_byte [MAXL];
  int         n_ev;
  int         last_ev_cycle;
  logic [7:0] last_ev_byte;

  // Holding-register model.
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ferr;
  logic       m_ovr;

  // Per-segment observations of the DUT.
  int         valid_pulses;
  int         ferr_pulses;
  logic [7:0] last_data;
  logic       ovr_seen;
  logic       prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic v, input logic r, input logic c);
    if (len < MAXL) begin
      line_a[len] = v;
      rdy_a[len]  = rnd_mode ? logic'($urandom_range(0, 2) != 0) : r;
      clr_a[len]  = rnd_mode ? logic'($urandom_range(0, 15) == 0) : c;
      len++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, cur_rdy, 1'b0);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < N; i++) push(1'b0, cur_rdy, 1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) push(b[k], cur_rdy, 1'b0);
    for (int i = 0; i < N; i++) push(stop, cur_rdy, 1'b0);
  endtask

  // Synchronised line as seen at posedge e (two flops behind the pin),
  // and its one-cycle-older copy. Outside the table the line is idle.
  function automatic logic rs(input int e);
    if (e >= 2 && e - 2 < len) return line_a[e-2];
    return 1'b1;
  endfunction

  function automatic logic rq(input int e);
    if (e >= 3 && e - 3 < len) return line_a[e-3];
    return 1'b1;
  endfunction

  // Frame decoding from the sample-point rules: edge seen at e, start check
  // at e+H, data bit k at e+H+(k+1)N, stop at e+H+9N.
  task automatic decode();
    int         e;
    int         s;
    logic [7:0] b;
    for (int i = 0; i < MAXL; i++) ev_kind[i] = 0;
    n_ev = 0;
    last_ev_cycle = -1;
    last_ev_byte = 8'h00;
    e = 0;
    while (e < len) begin
      if (rq(e) && !rs(e)) begin
        if (rs(e + H)) begin
          e = e + H + 1;
        end else begin
          for (int k = 0; k < 8; k++) b[k] = rs(e + H + (k + 1) * N);
          s = e + H + 9 * N;
          if (s < len) begin
            ev_kind[s] = rs(s) ? 1 : 2;
            ev_byte[s] = b;
            n_ev++;
            last_ev_cycle = s;
            last_ev_byte = b;
          end
          e = s + 1;
        end
      end else begin
        e++;
      end
    end
  endtask

  task automatic model_step(input int p);
    logic good;
    logic full_block;
    good       = (ev_kind[p] == 1);
    full_block = good && m_valid && !rdy_a[p];
    m_ferr     = (ev_kind[p] == 2);
    if (good && !full_block) begin
      m_data  = ev_byte[p];
      m_valid = 1'b1;
    end else if (m_valid && rdy_a[p]) begin
      m_valid = 1'b0;
    end
    if (full_block) m_ovr = 1'b1;
    else if (clr_a[p]) m_ovr = 1'b0;
  endtask

  task automatic run_seg();
    decode();
    @(negedge CLK);
    RST = 1'b1;
    RX = 1'b1;
    READY = 1'b1;
    CLR_ERR = 1'b0;
    @(negedge CLK);
    m_data = 8'h00;
    m_valid = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    check("rst_data", DATA, 8'h00);
    check("rst_valid", VALID, 1'b0);
    check("rst_ferr", FRAME_ERR, 1'b0);
    check("rst_ovr", OVERRUN, 1'b0);
    valid_pulses = 0;
    ferr_pulses = 0;
    last_data = 8'h00;
    ovr_seen = 1'b0;
    prev_valid = 1'b0;
    RX = line_a[0];
    READY = rdy_a[0];
    CLR_ERR = clr_a[0];
    RST = 1'b0;
    for (int p = 0; p < len; p++) begin
      @(posedge CLK);
      model_step(p);
      @(negedge CLK);
      check("data", DATA, m_data);
      check("valid", VALID, m_valid);
      check("frame_err", FRAME_ERR, m_ferr);
      check("overrun", OVERRUN, m_ovr);
      if (VALID && !prev_valid) begin
        valid_pulses++;
        last_data = DATA;
      end
      if (FRAME_ERR) ferr_pulses++;
      if (OVERRUN) ovr_seen = 1'b1;
      prev_valid = VALID;
      if (p + 1 < len) begin
        RX = line_a[p+1];
        READY = rdy_a[p+1];
        CLR_ERR = clr_a[p+1];
      end else begin
        RX = 1'b1;
        READY = 1'b1;
        CLR_ERR = 1'b0;
      end
    end
  endtask

  initial begin
    rnd_mode = 1'b0;
    cur_rdy = 1'b1;

    // Single frame 0x55.
    len = 0;
    idle(4);
    frame(8'h55, 1'b1);
    idle(8);
    run_seg();
    check("model_55_count", n_ev, 1);
    check("model_55_byte", last_ev_byte, 8'h55);
    check("model_55_stop_cycle", last_ev_cycle, 44);
    check("f55_pulses", valid_pulses, 1);
    check("f55_data", last_data, 8'h55);
    check("f55_ferr", ferr_pulses, 0);

    // Back-to-back frames with no idle gap.
    len = 0;
    idle(4);
    frame(8'hA3, 1'b1);
    frame(8'h0F, 1'b1);
    idle(8);
    run_seg();
    check("b2b_pulses", valid_pulses, 2);
    check("b2b_last", last_data, 8'h0F);
    check("b2b_ovr", ovr_seen, 1'b0);

    // One-cycle glitch, then a real frame shortly after.
    len = 0;
    idle(6);
    push(1'b0, 1'b1, 1'b0);
    idle(12);
    run_seg();
    check("glitch_pulses", valid_pulses, 0);
    check("glitch_ferr", ferr_pulses, 0);
    len = 0;
    idle(6);
    push(1'b0, 1'b1, 1'b0);
    idle(4);
    frame(8'h5A, 1'b1);
    idle(6);
    run_seg();
    check("glitch_recover", last_data, 8'h5A);

    // Bad stop bit, then a good frame.
    len = 0;
    idle(4);
    frame(8'h0F, 1'b0);
    idle(4);
    frame(8'h81, 1'b1);
    idle(6);
    run_seg();
    check("ferr_pulses", ferr_pulses, 1);
    check("ferr_then_good", valid_pulses, 1);
    check("ferr_good_data", last_data, 8'h81);

    // Overrun with READY low, one-cycle READY, then CLR_ERR.
    len = 0;
    cur_rdy = 1'b0;
    idle(4);
    frame(8'h11, 1'b1);
    frame(8'h22, 1'b1);
    idle(4);
    push(1'b1, 1'b1, 1'b0);
    idle(3);
    push(1'b1, 1'b0, 1'b1);
    idle(3);
    run_seg();
    check("ovr_seen", ovr_seen, 1'b1);
    check("ovr_end_data", DATA, 8'h11);
    check("ovr_end_valid", VALID, 1'b0);
    check("ovr_end_clr", OVERRUN, 1'b0);

    // Reset in the middle of a frame while VALID and OVERRUN are set.
    len = 0;
    cur_rdy = 1'b0;
    idle(4);
    frame(8'h99, 1'b1);
    frame(8'h77, 1'b1);
    idle(3);
    for (int i = 0; i < N; i++) push(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 * N; i++) push(logic'(i / N % 2), 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    run_seg();
    check("pre_rst_valid", VALID, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("midrst_data", DATA, 8'h00);
    check("midrst_valid", VALID, 1'b0);
    check("midrst_ferr", FRAME_ERR, 1'b0);
    check("midrst_ovr", OVERRUN, 1'b0);
    cur_rdy = 1'b1;
    len = 0;
    idle(4);
    frame(8'hC6, 1'b1);
    idle(6);
    run_seg();
    check("post_rst_pulses", valid_pulses, 1);
    check("post_rst_data", last_data, 8'hC6);

    // Randomised segments: random bytes, gaps, stop errors, glitches,
    // READY and CLR_ERR.
    rnd_mode = 1'b1;
    for (int s = 0; s < 6; s++) begin
      len = 0;
      idle(3);
      for (int f = 0; f < 12; f++) begin
        if ($urandom_range(0, 9) == 0) begin
          push(1'b0, 1'b1, 1'b0);
          idle($urandom_range(1, 6));
        end
        frame(8'($urandom), logic'($urandom_range(0, 7) != 0));
        idle($urandom_range(0, 2 * N));
      end
      idle(6);
      run_seg();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
